image_result_readout: RTL and testbench
=======================================

# image_result_readout

Wishbone read-side companion to the image capture path. It buffers CNN result words in a small FIFO and lets the host drain them, plus a status word, through single-cycle Wishbone classic reads. It marks frame completion when the CNN's last result word has been drained. It sits between the CNN result stream and the Caravel-side Wishbone slave bus.

## Interface
Parameters:
- DATA_WIDTH, 32, Wishbone and result word width
- DEPTH, 16, FIFO depth in words; must be a power of two
- DEPTH_LOG2, 4, log2(DEPTH)

Ports:
- wb_clk_i  in  1  Wishbone clock; the only clock
- wb_rst_i  in  1  reset; asynchronous assert, active-low (0 = reset)
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_adr_i  in  2  word offset: 0 = DATA, 1 = STATUS, 2 = reserved, 3 = CTRL
- wbs_dat_i  in  DATA_WIDTH  write data (ignored except at CTRL)
- wbs_ack_o  out  1  Wishbone acknowledge
- wbs_dat_o  out  DATA_WIDTH  read data
- result_valid_i  in  1  CNN result word valid
- result_data_i  in  DATA_WIDTH  CNN result word
- result_last_i  in  1  qualifies the final word of a frame
- result_ready_o  out  1  block accepts a result word this cycle
- readout_done_o  out  1  frame complete and FIFO fully drained

## Operation
- FIFO: write pointer, read pointer, and count (DEPTH_LOG2+1 bits). Pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- Bus request: req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o. Every req is acknowledged, whatever the address or direction.
- DATA read (adr 0, we 0):
  - Not empty: return the head word and advance the read pointer.
  - Empty: return 0 and set the sticky underflow flag.
- STATUS read (adr 1, we 0). Bits:
  - bit0 empty
  - bit1 full
  - bit2 done
  - bit3 underflow
  - bits[8+DEPTH_LOG2:8] count
  - all other bits 0
- Reserved read (adr 2) and CTRL read (adr 3) return 0.
- CTRL write (adr 3, we 1) with wbs_dat_i[0] = 1: clear. Pointers, count, done and underflow all go to 0. Writes to any other address, or with bit0 = 0, are acked and have no effect.
- Push: result_ready_o = ~full & ~done & ~clr_req, where clr_req is a CTRL clear request this cycle. A word is written when result_valid_i & result_ready_o.
- done is set when a word with result_last_i = 1 is pushed. It stays set until clear or reset; while set, no further words are accepted.
- readout_done_o = done & empty.
- Simultaneous push and DATA pop in one cycle: both happen and count is unchanged. When count = 0, the pop sees empty (underflow) and the pushed word stays.
- Reset is asynchronous. While wb_rst_i = 0, all state clears immediately, including a transaction in flight.

## Timing
- Reset values:
  - wbs_ack_o = 0
  - wbs_dat_o = 0
  - result_ready_o = 1 (FIFO empty, not done)
  - readout_done_o = 0
  - count = 0, pointers = 0, done = 0, underflow = 0
- Read latency is one cycle. When req is sampled at edge N, wbs_ack_o and wbs_dat_o are registered at edge N and stay valid for exactly one cycle. wbs_ack_o drops at edge N+1 even if stb is held.
- Back-to-back requests therefore take two cycles each; the ~wbs_ack_o term blocks a double pop.
- When wbs_ack_o = 0, wbs_dat_o = 0.
- Pop, clear and push pointer updates all occur on the edge that registers the ack (or the accepted handshake).
- result_ready_o and readout_done_o are combinational from registered state, plus clr_req for result_ready_o.
- A STATUS read returns state from before the edge: a push in the same cycle is not reflected.

## Test plan
- Reset, then STATUS read -> ack one cycle after stb; data 0x00000001 (empty); result_ready_o = 1; readout_done_o = 0.
- Push 0xA0..0xA3 with last on 0xA3, then read DATA four times -> returns 0xA0, 0xA1, 0xA2, 0xA3 in order. result_ready_o is 0 after 0xA3 is pushed. readout_done_o rises after the 4th pop; STATUS = 0x00000005.
- Push 16 words without last -> result_ready_o low once count = 16; STATUS = 0x00001002. Pop one while valid is held -> the 17th word is accepted on the next cycle.
- DATA read when empty -> data 0 and STATUS bit3 set. CTRL write 0x1 -> STATUS = 0x00000001, and result_ready_o is re-enabled after done.
- Sustained push and pop (stb held for two cycles per read) at count 3 -> count stays 3; data order is preserved across the pointer wrap past index 15.
- Assert wb_rst_i = 0 mid-ack with count = 5 -> wbs_ack_o drops without waiting for an edge; count = 0 after reset release.

Source files
------------

// File: rtl/image_result_readout.sv
// Wishbone readout of buffered CNN result words: DATA pops the FIFO head, STATUS reports
// FIFO and frame state, CTRL bit0 clears everything. A frame is complete once its last word drains.
module image_result_readout #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [1:0]            wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic                  result_valid_i,
  input  logic [DATA_WIDTH-1:0] result_data_i,
  input  logic                  result_last_i,
  output logic                  result_ready_o,
  output logic                  readout_done_o
);

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  done_reg, underflow_reg;
  logic                  ack_reg;
  logic [DATA_WIDTH-1:0] dat_reg;

  logic                  empty, full, req, rd_req, data_rd, pop, push, clr_req;
  logic [DATA_WIDTH-1:0] status_word, read_data;
  logic                  unused_dat;

  assign unused_dat = ^wbs_dat_i[DATA_WIDTH-1:1];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign rd_req  = req & ~wbs_we_i;
  assign data_rd = rd_req & (wbs_adr_i == 2'd0);
  assign pop     = data_rd & ~empty;
  assign clr_req = req & wbs_we_i & (wbs_adr_i == 2'd3) & wbs_dat_i[0];

  assign result_ready_o = ~full & ~done_reg & ~clr_req;
  assign push           = result_valid_i & result_ready_o;
  assign readout_done_o = done_reg & empty;

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

  always_comb begin
    status_word                   = '0;
    status_word[0]                = empty;
    status_word[1]                = full;
    status_word[2]                = done_reg;
    status_word[3]                = underflow_reg;
    status_word[8 +: DEPTH_LOG2+1] = count_reg;
  end

  always_comb begin
    read_data = '0;
    if (rd_req) begin
      case (wbs_adr_i)
        2'd0:    read_data = empty ? '0 : mem[rd_ptr_reg];
        2'd1:    read_data = status_word;
        default: read_data = '0;
      endcase
    end
  end

  // Storage carries no reset so it can map onto RAM; only the pointers define validity.
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr_reg] <= result_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
      underflow_reg <= 1'b0;
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
    end else begin
      ack_reg <= req;
      dat_reg <= read_data;
      if (clr_req) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
        done_reg      <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          if (result_last_i)
            done_reg <= 1'b1;
        end
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        if (data_rd & empty)
          underflow_reg <= 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_ONE;
          2'b01:   count_reg <= count_reg - CNT_ONE;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_result_readout.sv
// Directed bench for image_result_readout: bus reads/writes, FIFO push/pop, done, clear, async reset.
module tb_image_result_readout;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [1:0]  wbs_adr_i = 2'd0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        result_valid_i = 1'b0;
  logic [31:0] result_data_i = '0;
  logic        result_last_i = 1'b0;
  logic        result_ready_o;
  logic        readout_done_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  image_result_readout #(.DATA_WIDTH(32), .DEPTH(16), .DEPTH_LOG2(4)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .result_valid_i (result_valid_i),
    .result_data_i  (result_data_i),
    .result_last_i  (result_last_i),
    .result_ready_o (result_ready_o),
    .readout_done_o (readout_done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%08h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic wb_read(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
    @(posedge wb_clk_i); #1;
    check_val({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd1);
    check_val(tag, wbs_dat_o, exp);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_write(input string tag, input logic [1:0] adr, input logic [31:0] dat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = adr; wbs_dat_i = dat;
    @(posedge wb_clk_i); #1;
    check_val(tag, {31'd0, wbs_ack_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_dat_i = '0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    result_valid_i = 1'b1; result_data_i = d; result_last_i = last;
    @(posedge wb_clk_i); #1;
    result_valid_i = 1'b0; result_last_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #1 wb_rst_i = 1'b0;
    #1;
    check_val("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check_val("rst_dat", wbs_dat_o, 32'd0);
    check_val("rst_ready", {31'd0, result_ready_o}, 32'd1);
    check_val("rst_done", {31'd0, readout_done_o}, 32'd0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;

    wb_read("status_rst", 2'd1, 32'h0000_0001);
    check_val("ready_idle", {31'd0, result_ready_o}, 32'd1);
    check_val("done_idle", {31'd0, readout_done_o}, 32'd0);

    // Frame of four words, last on 0xA3
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i, i == 3);
    check_val("ready_after_last", {31'd0, result_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wb_read("pop_frame", 2'd0, 32'hA0 + i);
      if (i == 2) check_val("done_before_end", {31'd0, readout_done_o}, 32'd0);
    end
    check_val("done_drained", {31'd0, readout_done_o}, 32'd1);
    wb_read("status_done", 2'd1, 32'h0000_0005);
    check_val("ready_while_done", {31'd0, result_ready_o}, 32'd0);

    wb_write("clr_ack", 2'd3, 32'h1);
    wb_read("status_clr", 2'd1, 32'h0000_0001);
    check_val("ready_after_clr", {31'd0, result_ready_o}, 32'd1);

    // Underflow and a non-clearing CTRL write
    wb_read("pop_empty", 2'd0, 32'h0);
    wb_read("status_uflow", 2'd1, 32'h0000_0009);
    wb_write("ctrl_noclr", 2'd3, 32'h2);
    wb_read("status_keep", 2'd1, 32'h0000_0009);
    wb_read("reserved_rd", 2'd2, 32'h0);
    wb_write("clr2_ack", 2'd3, 32'h1);
    wb_read("status_clr2", 2'd1, 32'h0000_0001);

    // Fill to full, then pop while a 17th word waits
    for (int i = 0; i < 16; i++) push_word(32'hB0 + i, 1'b0);
    check_val("ready_full", {31'd0, result_ready_o}, 32'd0);
    wb_read("status_full", 2'd1, 32'h0000_1002);
    result_valid_i = 1'b1; result_data_i = 32'hC0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 2'd0;
    @(posedge wb_clk_i); #1;
    check_val("pop_full_ack", {31'd0, wbs_ack_o}, 32'd1);
    check_val("pop_full", wbs_dat_o, 32'hB0);
    check_val("ready_reopen", {31'd0, result_ready_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    result_valid_i = 1'b0;
    check_val("ready_refull", {31'd0, result_ready_o}, 32'd0);
    wb_read("status_refull", 2'd1, 32'h0000_1002);
    for (int i = 1; i < 16; i++) wb_read("drain", 2'd0, 32'hB0 + i);
    wb_read("drain_last", 2'd0, 32'hC0);
    wb_read("status_drain", 2'd1, 32'h0000_0001);

    // Sustained push/pop at count 3, wrapping the pointers
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      push_word(32'hD0 + i, 1'b0);
      exp_q.push_back(32'hD0 + i);
    end
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 2'd0;
    for (int i = 0; i < 16; i++) begin
      result_valid_i = 1'b1; result_data_i = 32'h100 + i;
      exp_q.push_back(32'h100 + i);
      @(posedge wb_clk_i); #1;
      exp_word = exp_q.pop_front();
      check_val("stream_ack", {31'd0, wbs_ack_o}, 32'd1);
      check_val("stream_pop", wbs_dat_o, exp_word);
      result_valid_i = 1'b0;
      @(posedge wb_clk_i); #1;
      check_val("held_ack_drop", {31'd0, wbs_ack_o}, 32'd0);
      check_val("idle_dat", wbs_dat_o, 32'd0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wb_read("status_stream", 2'd1, 32'h0000_0300);

    // Async reset in the middle of an ack, count = 5
    push_word(32'h200, 1'b0);
    push_word(32'h201, 1'b0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 2'd1;
    @(posedge wb_clk_i); #1;
    check_val("status_cnt5", wbs_dat_o, 32'h0000_0500);
    #2 wb_rst_i = 1'b0;
    #1;
    check_val("async_ack", {31'd0, wbs_ack_o}, 32'd0);
    check_val("async_dat", wbs_dat_o, 32'd0);
    check_val("async_ready", {31'd0, result_ready_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_read("status_postrst", 2'd1, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
